// File: rtl/ifid_queue.sv
// Fetch-to-decode instruction queue: circular buffer of (PC, instruction) pairs with
// full-based fetch stall, flush on taken control transfer, and valid/ready pop.
module ifid_queue #(
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           fetch_valid,
  input  logic [ADDR_WIDTH-1:0]          fetch_pc,
  input  logic [INSTR_WIDTH-1:0]         fetch_instr,
  output logic                           fetch_stall,
  input  logic                           flush,
  input  logic                           dec_ready,
  output logic                           dec_valid,
  output logic [ADDR_WIDTH-1:0]          dec_pc,
  output logic [ADDR_WIDTH-1:0]          dec_pc_next,
  output logic [INSTR_WIDTH-1:0]         dec_instr,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0]  mem_pc_q    [DEPTH];
  logic [INSTR_WIDTH-1:0] mem_instr_q [DEPTH];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic full, empty, push, pop;

  // Status comes only from registered count, so no dec_ready -> fetch_stall path exists.
  always_comb begin
    full  = (count_q == CntW'(DEPTH));
    empty = (count_q == '0);
    push  = fetch_valid & ~full & ~flush;
    pop   = ~empty & dec_ready & ~flush;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_instr_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_pc_q[wr_ptr_q]    <= fetch_pc;
        mem_instr_q[wr_ptr_q] <= fetch_instr;
      end
    end
  end

  // Empty queue presents zeros so dec_instr reads as a NOP.
  always_comb begin
    fetch_stall = full;
    dec_valid   = ~empty;
    occupancy   = count_q;
    dec_pc      = '0;
    dec_instr   = '0;
    if (!empty) begin
      dec_pc    = mem_pc_q[rd_ptr_q];
      dec_instr = mem_instr_q[rd_ptr_q];
    end
    dec_pc_next = dec_pc + ADDR_WIDTH'(1);
  end

endmodule

// File: tb/tb_ifid_queue.sv
// Self-checking bench for ifid_queue: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model.
module tb_ifid_queue;

  localparam int unsigned AW    = 20;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned OW    = 2 + AW + AW + IW + CW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          fetch_valid = 1'b0;
  logic [AW-1:0] fetch_pc = '0;
  logic [IW-1:0] fetch_instr = '0;
  logic          fetch_stall;
  logic          flush = 1'b0;
  logic          dec_ready = 1'b0;
  logic          dec_valid;
  logic [AW-1:0] dec_pc;
  logic [AW-1:0] dec_pc_next;
  logic [IW-1:0] dec_instr;
  logic [CW-1:0] occupancy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } entry_t;

  entry_t mq[$];

  logic [OW-1:0] obs;
  assign obs = {fetch_stall, dec_valid, dec_pc, dec_pc_next, dec_instr, occupancy};

  localparam logic [OW-1:0] ResetOut = {1'b0, 1'b0, {AW{1'b0}}, AW'(1), {IW{1'b0}}, {CW{1'b0}}};

  ifid_queue #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .DEPTH      (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .fetch_valid(fetch_valid),
    .fetch_pc   (fetch_pc),
    .fetch_instr(fetch_instr),
    .fetch_stall(fetch_stall),
    .flush      (flush),
    .dec_ready  (dec_ready),
    .dec_valid  (dec_valid),
    .dec_pc     (dec_pc),
    .dec_pc_next(dec_pc_next),
    .dec_instr  (dec_instr),
    .occupancy  (occupancy)
  );

  always #5 clock = ~clock;

  function automatic logic [OW-1:0] model_out();
    logic          v;
    logic [AW-1:0] pc;
    logic [AW-1:0] pn;
    logic [IW-1:0] ins;
    v   = (mq.size() != 0);
    pc  = v ? mq[0].pc : '0;
    ins = v ? mq[0].instr : '0;
    pn  = pc + 1'b1;
    return {(mq.size() == DEPTH), v, pc, pn, ins, CW'(mq.size())};
  endfunction

  // Drive one cycle of inputs, advance the model, and land #1 after the edge.
  task automatic tick(input logic rst, input logic fl, input logic fv, input logic [AW-1:0] pc,
                      input logic [IW-1:0] ins, input logic rdy);
    logic full_now;
    reset       = rst;
    flush       = fl;
    fetch_valid = fv;
    fetch_pc    = pc;
    fetch_instr = ins;
    dec_ready   = rdy;
    full_now    = (mq.size() == DEPTH);
    @(posedge clock);
    if (rst || fl) begin
      mq.delete();
    end else begin
      if (rdy && mq.size() != 0) void'(mq.pop_front());
      if (fv && !full_now) mq.push_back('{pc: pc, instr: ins});
    end
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0, 1'b1, AW'('h10), 32'h1234_5678, 1'b0);
      total++;
      if (obs !== ResetOut) begin
        bad++;
        $display("FAIL reset[%0d]: got %h want %h", i, obs, ResetOut);
      end
    end
    idle_inputs();
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b1, AW'(i), 32'hA000_0000 + IW'(i), 1'b1);
      total++;
      if (dec_pc !== AW'(i) || occupancy !== CW'(1) || fetch_stall !== 1'b0
          || obs !== model_out()) begin
        bad++;
        $display("FAIL stream[%0d]: got pc=%h occ=%0d stall=%b all=%h want pc=%h occ=1 stall=0 all=%h",
                 i, dec_pc, occupancy, fetch_stall, obs, AW'(i), model_out());
      end
    end
    tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    total++;
    if (obs !== ResetOut) begin
      bad++;
      $display("FAIL stream_drain: got %h want %h", obs, ResetOut);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b1, AW'(i), 32'hB000_0000 + IW'(i), 1'b0);
    end
    total++;
    if (occupancy !== CW'(2) || fetch_stall !== 1'b1 || dec_pc !== AW'(0)
        || dec_instr !== 32'hB000_0000) begin
      bad++;
      $display("FAIL bp_full: got occ=%0d stall=%b pc=%h instr=%h want occ=2 stall=1 pc=0 instr=b0000000",
               occupancy, fetch_stall, dec_pc, dec_instr);
    end
    // Raising dec_ready must not lower the stall within the same cycle.
    dec_ready = 1'b1;
    fetch_valid = 1'b0;
    #1;
    total++;
    if (fetch_stall !== 1'b1) begin
      bad++;
      $display("FAIL bp_stall_comb: got stall=%b want 1", fetch_stall);
    end
    tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    total++;
    if (dec_pc !== AW'(1) || fetch_stall !== 1'b0 || occupancy !== CW'(1)) begin
      bad++;
      $display("FAIL bp_pop0: got pc=%h stall=%b occ=%0d want pc=1 stall=0 occ=1",
               dec_pc, fetch_stall, occupancy);
    end
    tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    total++;
    if (obs !== ResetOut) begin
      bad++;
      $display("FAIL bp_pop1: got %h want %h", obs, ResetOut);
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    tick(1'b0, 1'b0, 1'b1, AW'('h100), 32'hC000_0001, 1'b0);
    tick(1'b0, 1'b0, 1'b1, AW'('h101), 32'hC000_0002, 1'b0);
    total++;
    if (occupancy !== CW'(2)) begin
      bad++;
      $display("FAIL flush_fill: got occ=%0d want 2", occupancy);
    end
    tick(1'b0, 1'b1, 1'b1, AW'('h102), 32'hC000_0003, 1'b1);
    total++;
    if (occupancy !== CW'(0) || dec_valid !== 1'b0 || obs !== ResetOut) begin
      bad++;
      $display("FAIL flush_empty: got %h want %h", obs, ResetOut);
    end
    tick(1'b0, 1'b0, 1'b1, AW'('h0F1F), 32'hD000_0000, 1'b0);
    total++;
    if (dec_valid !== 1'b1 || dec_pc !== AW'('h0F1F) || dec_instr !== 32'hD000_0000) begin
      bad++;
      $display("FAIL flush_refill: got v=%b pc=%h instr=%h want v=1 pc=00f1f instr=d0000000",
               dec_valid, dec_pc, dec_instr);
    end
    tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_pc_wrap();
    tick(1'b0, 1'b0, 1'b1, AW'('hFFFFF), 32'hE000_0000, 1'b0);
    total++;
    if (dec_pc !== AW'('hFFFFF) || dec_pc_next !== AW'(0)) begin
      bad++;
      $display("FAIL pc_wrap: got pc=%h next=%h want pc=fffff next=00000", dec_pc, dec_pc_next);
    end
    tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_reset_mid();
    tick(1'b0, 1'b0, 1'b1, AW'('h200), 32'hF000_0000, 1'b0);
    tick(1'b0, 1'b0, 1'b1, AW'('h201), 32'hF000_0001, 1'b0);
    tick(1'b1, 1'b0, 1'b1, AW'('h202), 32'hF000_0002, 1'b1);
    total++;
    if (obs !== ResetOut) begin
      bad++;
      $display("FAIL reset_mid: got %h want %h", obs, ResetOut);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(63) == 0), ($urandom_range(15) == 0), 1'($urandom),
           AW'($urandom), IW'($urandom), 1'($urandom));
      total++;
      if (obs !== model_out()) begin
        bad++;
        $display("FAIL random[%0d]: got %h want %h", i, obs, model_out());
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_pc_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
